ahb_phase_mux: RTL and testbench

Master-side AHB payload multiplexer that separates address-phase and data-phase selection. Address-phase payload (HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT bundle) follows the current one-hot grant combinationally. Write-data-phase payload follows a registered copy of the grant, captured only when the bus HREADY is high, so HWDATA stays aligned with the transfer it belongs to. The block sits between the arbiter and each slave port of the generated interconnect, one instance per slave. It generalises the flat one-hot mux to N channels with pipelined phase tracking and grant-error reporting.

---
 rtl/ahb_phase_mux_pkg.sv | 26 ++
 rtl/ahb_phase_mux_onehot_mux.sv | 27 ++
 rtl/ahb_phase_mux.sv | 66 ++++++
 tb/tb_ahb_phase_mux.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_phase_mux_pkg.sv
// Shared constants and grant-validity decode for the AHB phase multiplexer.
package ahb_phase_mux_pkg;

  localparam int ADDR_LOAD_DEF = 46;
  localparam int DATA_LOAD_DEF = 32;
  localparam int MAX_CHANNELS  = 16;

  typedef enum logic [1:0] {
    SEL_ZERO   = 2'd0,
    SEL_ONEHOT = 2'd1,
    SEL_MULTI  = 2'd2
  } sel_kind_e;

  // Classify a grant vector (zero-extended to MAX_CHANNELS) by its population count.
  function automatic sel_kind_e onehot_check(input logic [MAX_CHANNELS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      n += 32'(v[i]);
    end
    if (n == 0) return SEL_ZERO;
    else if (n == 1) return SEL_ONEHOT;
    else return SEL_MULTI;
  endfunction

endpackage

// File: rtl/ahb_phase_mux_onehot_mux.sv
// Combinational one-hot payload selector; a grant that is not one-hot yields zero.
module ahb_onehot_mux
  import ahb_phase_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
) (
  input  logic [CHANNELS-1:0]            sel,
  input  logic [CHANNELS-1:0][WIDTH-1:0] payload,
  output logic [WIDTH-1:0]               mux_out
);

  logic [MAX_CHANNELS-1:0] sel_ext;

  // Pass the granted channel's payload only when exactly one grant bit is set.
  always_comb begin
    sel_ext                 = '0;
    sel_ext[CHANNELS-1:0]   = sel;
    mux_out                 = '0;
    if (onehot_check(sel_ext) == SEL_ONEHOT) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel[i]) mux_out = payload[i];
      end
    end
  end

endmodule

// File: rtl/ahb_phase_mux.sv
// Per-slave AHB payload mux: address phase follows the live grant, write data
// follows the grant registered at the hready-high edge that accepted the address.
module ahb_phase_mux
  import ahb_phase_mux_pkg::*;
#(
  parameter int CHANNEL_NUM = 4,
  parameter int ADDR_LOAD   = ADDR_LOAD_DEF,
  parameter int DATA_LOAD   = DATA_LOAD_DEF
) (
  input  logic                                  HCLK,
  input  logic                                  HRESET,
  input  logic [CHANNEL_NUM-1:0][ADDR_LOAD-1:0] addr_in,
  input  logic [CHANNEL_NUM-1:0][DATA_LOAD-1:0] data_in,
  input  logic [CHANNEL_NUM-1:0]                sel,
  input  logic                                  hready,
  output logic [ADDR_LOAD-1:0]                  addr_out,
  output logic [DATA_LOAD-1:0]                  data_out,
  output logic [CHANNEL_NUM-1:0]                dsel_out,
  output logic                                  sel_err
);

  logic [CHANNEL_NUM-1:0]  dsel;
  logic [MAX_CHANNELS-1:0] sel_ext;
  sel_kind_e               sel_kind;

  // Decode the validity of the incoming address-phase grant.
  always_comb begin
    sel_ext                  = '0;
    sel_ext[CHANNEL_NUM-1:0] = sel;
    sel_kind                 = onehot_check(sel_ext);
  end

  // Data-phase owner and grant-error pulse advance only on an hready-high edge; reset wins.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel    <= '0;
      sel_err <= 1'b0;
    end else begin
      sel_err <= hready && (sel_kind == SEL_MULTI);
      if (hready) begin
        dsel <= (sel_kind == SEL_ONEHOT) ? sel : '0;
      end
    end
  end

  assign dsel_out = dsel;

  ahb_onehot_mux #(
    .CHANNELS (CHANNEL_NUM),
    .WIDTH    (ADDR_LOAD)
  ) u_addr_mux (
    .sel     (sel),
    .payload (addr_in),
    .mux_out (addr_out)
  );

  ahb_onehot_mux #(
    .CHANNELS (CHANNEL_NUM),
    .WIDTH    (DATA_LOAD)
  ) u_data_mux (
    .sel     (dsel),
    .payload (data_in),
    .mux_out (data_out)
  );

endmodule

// File: tb/tb_ahb_phase_mux.sv
// Bench for ahb_phase_mux: directed scenarios, randomized traffic against an
// owner-index model, and a walking-grant sweep over 2, 4 and 16 channels.
module tb_ahb_phase_mux;

  localparam int N  = 4;
  localparam int AW = 46;
  localparam int DW = 32;

  logic HCLK = 1'b0;
  logic HRESET;
  logic hready;
  logic [N-1:0][AW-1:0] addr_in;
  logic [N-1:0][DW-1:0] data_in;
  logic [N-1:0]         sel;
  logic [AW-1:0]        addr_out;
  logic [DW-1:0]        data_out;
  logic [N-1:0]         dsel_out;
  logic                 sel_err;

  logic [1:0][AW-1:0]  addr2;
  logic [1:0][DW-1:0]  data2;
  logic [1:0]          sel2;
  logic [AW-1:0]       addr_out2;
  logic [DW-1:0]       data_out2;
  logic [1:0]          dsel_out2;
  logic                sel_err2;

  logic [15:0][AW-1:0] addr16;
  logic [15:0][DW-1:0] data16;
  logic [15:0]         sel16;
  logic [AW-1:0]       addr_out16;
  logic [DW-1:0]       data_out16;
  logic [15:0]         dsel_out16;
  logic                sel_err16;

  int checks   = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  ahb_phase_mux #(.CHANNEL_NUM(N), .ADDR_LOAD(AW), .DATA_LOAD(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .addr_in(addr_in), .data_in(data_in), .sel(sel),
    .hready(hready), .addr_out(addr_out), .data_out(data_out), .dsel_out(dsel_out),
    .sel_err(sel_err));

  ahb_phase_mux #(.CHANNEL_NUM(2), .ADDR_LOAD(AW), .DATA_LOAD(DW)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .addr_in(addr2), .data_in(data2), .sel(sel2),
    .hready(hready), .addr_out(addr_out2), .data_out(data_out2), .dsel_out(dsel_out2),
    .sel_err(sel_err2));

  ahb_phase_mux #(.CHANNEL_NUM(16), .ADDR_LOAD(AW), .DATA_LOAD(DW)) dut16 (
    .HCLK(HCLK), .HRESET(HRESET), .addr_in(addr16), .data_in(data16), .sel(sel16),
    .hready(hready), .addr_out(addr_out16), .data_out(data_out16), .dsel_out(dsel_out16),
    .sel_err(sel_err16));

  // Reference model for the 4-channel instance: data-phase owner as a channel index (-1 = none).
  int   m_owner = -1;
  logic m_err   = 1'b0;

  always @(posedge HCLK) begin
    int c, idx;
    c = 0; idx = -1;
    for (int i = 0; i < N; i++) if (sel[i]) begin c++; idx = i; end
    if (HRESET) begin
      m_owner = -1;
      m_err   = 1'b0;
    end else begin
      m_err = hready && (c >= 2);
      if (hready) m_owner = (c == 1) ? idx : -1;
    end
  end

  function automatic logic [AW-1:0] exp_addr();
    int c, idx;
    c = 0; idx = 0;
    for (int i = 0; i < N; i++) if (sel[i]) begin c++; idx = i; end
    return (c == 1) ? addr_in[idx] : '0;
  endfunction

  function automatic logic [DW-1:0] exp_data();
    return (m_owner >= 0) ? data_in[m_owner] : '0;
  endfunction

  function automatic logic [N-1:0] exp_dsel();
    return (m_owner >= 0) ? N'(1 << m_owner) : '0;
  endfunction

  task automatic test_reset();
    HRESET = 1'b1; hready = 1'b0; sel = 4'b0010;
    addr_in[1] = 46'h2_5555_0000;
    #1;
    checks++;
    if (addr_out !== 46'h2_5555_0000) begin
      failures++; $display("FAIL reset_addr_live actual=%h required=%h", addr_out, 46'h2_5555_0000);
    end
    @(posedge HCLK); #1;
    checks++;
    if (dsel_out !== 4'b0000) begin
      failures++; $display("FAIL reset_dsel actual=%b required=0000", dsel_out);
    end
    checks++;
    if (sel_err !== 1'b0) begin
      failures++; $display("FAIL reset_err actual=%b required=0", sel_err);
    end
    checks++;
    if (data_out !== 32'h0) begin
      failures++; $display("FAIL reset_data actual=%h required=0", data_out);
    end
    HRESET = 1'b0; sel = '0;
  endtask

  task automatic test_basic();
    sel = 4'b0010; hready = 1'b1;
    addr_in[1] = 46'h1234; data_in[1] = 32'hCAFE0001;
    #1;
    checks++;
    if (addr_out !== 46'h1234) begin
      failures++; $display("FAIL basic_addr actual=%h required=%h", addr_out, 46'h1234);
    end
    @(posedge HCLK); #1;
    sel = '0;
    checks++;
    if (dsel_out !== 4'b0010) begin
      failures++; $display("FAIL basic_dsel actual=%b required=0010", dsel_out);
    end
    checks++;
    if (data_out !== 32'hCAFE0001) begin
      failures++; $display("FAIL basic_data actual=%h required=CAFE0001", data_out);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_back_to_back();
    addr_in[0] = 46'h1_0000; addr_in[3] = 46'h3_3333;
    data_in[0] = 32'hD000_0000; data_in[3] = 32'hD000_0003;
    hready = 1'b1; sel = 4'b0001;
    @(posedge HCLK); #1;
    sel = 4'b1000;
    #1;
    checks++;
    if (addr_out !== 46'h3_3333) begin
      failures++; $display("FAIL b2b_addr_b actual=%h required=%h", addr_out, 46'h3_3333);
    end
    checks++;
    if (data_out !== 32'hD000_0000) begin
      failures++; $display("FAIL b2b_data_a actual=%h required=D0000000", data_out);
    end
    @(posedge HCLK); #1;
    sel = '0;
    checks++;
    if (data_out !== 32'hD000_0003) begin
      failures++; $display("FAIL b2b_data_b actual=%h required=D0000003", data_out);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_wait_states();
    data_in[0] = 32'hA0A0_0000; data_in[2] = 32'hA0A0_0002; addr_in[2] = 46'h22_2222;
    hready = 1'b1; sel = 4'b0001;
    @(posedge HCLK); #1;
    sel = 4'b0100; hready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (addr_out !== 46'h22_2222) begin
        failures++; $display("FAIL wait_addr_follow cyc=%0d actual=%h required=%h", k, addr_out, 46'h22_2222);
      end
      @(posedge HCLK); #1;
      checks++;
      if (data_out !== 32'hA0A0_0000) begin
        failures++; $display("FAIL wait_data_hold cyc=%0d actual=%h required=A0A00000", k, data_out);
      end
    end
    hready = 1'b1;
    @(posedge HCLK); #1;
    sel = '0;
    checks++;
    if (dsel_out !== 4'b0100) begin
      failures++; $display("FAIL wait_dsel_adv actual=%b required=0100", dsel_out);
    end
    checks++;
    if (data_out !== 32'hA0A0_0002) begin
      failures++; $display("FAIL wait_data_adv actual=%h required=A0A00002", data_out);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_illegal();
    hready = 1'b1; sel = 4'b0110;
    #1;
    checks++;
    if (addr_out !== '0) begin
      failures++; $display("FAIL illegal_addr actual=%h required=0", addr_out);
    end
    @(posedge HCLK); #1;
    sel = '0;
    checks++;
    if (dsel_out !== 4'b0000) begin
      failures++; $display("FAIL illegal_dsel actual=%b required=0000", dsel_out);
    end
    checks++;
    if (data_out !== 32'h0) begin
      failures++; $display("FAIL illegal_data actual=%h required=0", data_out);
    end
    checks++;
    if (sel_err !== 1'b1) begin
      failures++; $display("FAIL illegal_err_set actual=%b required=1", sel_err);
    end
    @(posedge HCLK); #1;
    checks++;
    if (sel_err !== 1'b0) begin
      failures++; $display("FAIL illegal_err_pulse actual=%b required=0", sel_err);
    end
    sel = 4'b0110; hready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge HCLK); #1;
      checks++;
      if (sel_err !== 1'b0) begin
        failures++; $display("FAIL illegal_wait_noerr cyc=%0d actual=%b required=0", k, sel_err);
      end
    end
    sel = '0; hready = 1'b1;
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset_mid();
    data_in[1] = 32'hBEEF_0001;
    hready = 1'b1; sel = 4'b0010;
    @(posedge HCLK); #1;
    hready = 1'b0; HRESET = 1'b1;
    @(posedge HCLK); #1;
    checks++;
    if (dsel_out !== 4'b0000) begin
      failures++; $display("FAIL rstmid_dsel actual=%b required=0000", dsel_out);
    end
    checks++;
    if (data_out !== 32'h0) begin
      failures++; $display("FAIL rstmid_data actual=%h required=0", data_out);
    end
    sel = 4'b0110; hready = 1'b1;
    @(posedge HCLK); #1;
    checks++;
    if (sel_err !== 1'b0) begin
      failures++; $display("FAIL rst_wins_err actual=%b required=0", sel_err);
    end
    HRESET = 1'b0; sel = '0;
    @(posedge HCLK); #1;
    checks++;
    if (sel_err !== 1'b0) begin
      failures++; $display("FAIL rst_after_err actual=%b required=0", sel_err);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5) sel = N'(1 << $urandom_range(0, N - 1));
      else if (r < 7) sel = '0;
      else sel = N'($urandom);
      hready = ($urandom_range(0, 3) != 0);
      HRESET = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++) begin
        addr_in[i] = AW'({$urandom, $urandom});
        data_in[i] = $urandom;
      end
      #1;
      checks++;
      if (addr_out !== exp_addr()) begin
        failures++; $display("FAIL rand_addr k=%0d actual=%h required=%h", k, addr_out, exp_addr());
      end
      checks++;
      if (data_out !== exp_data()) begin
        failures++; $display("FAIL rand_data_pre k=%0d actual=%h required=%h", k, data_out, exp_data());
      end
      @(posedge HCLK); #1;
      checks++;
      if (dsel_out !== exp_dsel()) begin
        failures++; $display("FAIL rand_dsel k=%0d actual=%b required=%b", k, dsel_out, exp_dsel());
      end
      checks++;
      if (sel_err !== m_err) begin
        failures++; $display("FAIL rand_err k=%0d actual=%b required=%b", k, sel_err, m_err);
      end
      checks++;
      if (data_out !== exp_data()) begin
        failures++; $display("FAIL rand_data_post k=%0d actual=%h required=%h", k, data_out, exp_data());
      end
    end
    HRESET = 1'b0; sel = '0; hready = 1'b1;
    @(posedge HCLK); #1;
  endtask

  task automatic test_sweep();
    hready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      addr2[i] = AW'(46'h2_0000_0000 + i); data2[i] = 32'h2200_0000 + i;
    end
    for (int i = 0; i < N; i++) begin
      addr_in[i] = AW'(46'h4_0000_0000 + i); data_in[i] = 32'h4400_0000 + i;
    end
    for (int i = 0; i < 16; i++) begin
      addr16[i] = AW'(46'h16_0000_0000 + i); data16[i] = 32'h1600_0000 + i;
    end
    for (int i = 0; i < 16; i++) begin
      sel2  = (i < 2) ? 2'(1 << i) : '0;
      sel   = (i < N) ? N'(1 << i) : '0;
      sel16 = 16'(1 << i);
      #1;
      checks++;
      if (addr_out16 !== AW'(46'h16_0000_0000 + i)) begin
        failures++; $display("FAIL sweep16_addr ch=%0d actual=%h required=%h", i, addr_out16, AW'(46'h16_0000_0000 + i));
      end
      if (i > 0) begin
        checks++;
        if (data_out16 !== 32'h1600_0000 + 32'(i - 1)) begin
          failures++; $display("FAIL sweep16_early ch=%0d actual=%h required=%h", i, data_out16, 32'h1600_0000 + 32'(i - 1));
        end
      end
      @(posedge HCLK); #1;
      checks++;
      if (data_out16 !== 32'h1600_0000 + 32'(i)) begin
        failures++; $display("FAIL sweep16_data ch=%0d actual=%h required=%h", i, data_out16, 32'h1600_0000 + 32'(i));
      end
      if (i < 2) begin
        checks++;
        if (data_out2 !== 32'h2200_0000 + 32'(i)) begin
          failures++; $display("FAIL sweep2_data ch=%0d actual=%h required=%h", i, data_out2, 32'h2200_0000 + 32'(i));
        end
      end
      if (i < N) begin
        checks++;
        if (data_out !== 32'h4400_0000 + 32'(i)) begin
          failures++; $display("FAIL sweep4_data ch=%0d actual=%h required=%h", i, data_out, 32'h4400_0000 + 32'(i));
        end
      end
    end
    sel = '0; sel2 = '0; sel16 = '0;
    @(posedge HCLK); #1;
  endtask

  initial begin
    HRESET = 1'b1; hready = 1'b0; sel = '0; addr_in = '0; data_in = '0;
    sel2 = '0; addr2 = '0; data2 = '0; sel16 = '0; addr16 = '0; data16 = '0;
    @(posedge HCLK); #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_wait_states();
    test_illegal();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
